// File: rtl/fp16_pkg.sv
// Shared FP16 (IEEE binary16) field layout, constants and field helpers.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int MANT_W = 10;
    localparam int BIAS   = 15;

    localparam logic [15:0] FP16_ZERO    = 16'h0000;
    localparam logic [14:0] FP16_MAX_MAG = 15'h7BFF;

    function automatic logic get_sign(input logic [15:0] x);
        return x[15];
    endfunction

    function automatic logic [EXP_W-1:0] get_exp(input logic [15:0] x);
        return x[14:10];
    endfunction

    function automatic logic [MANT_W-1:0] get_mant(input logic [15:0] x);
        return x[9:0];
    endfunction

    // Subnormals are flushed, so exponent field 0 means zero.
    function automatic logic is_zero(input logic [15:0] x);
        return x[14:10] == '0;
    endfunction

endpackage

// File: rtl/fp16_add_core.sv
// Combinational FP16 adder: truncating alignment, no rounding,
// saturation to +-0x7BFF, flush of underflow and exact zero to +0.
module fp16_add_core
    import fp16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    logic        swap;
    logic [15:0] op_l;
    logic [15:0] op_s;
    logic [4:0]  shift;
    logic [10:0] mant_l;
    logic [10:0] mant_s;

    // op_l is the larger magnitude; the smaller one is shifted toward it
    assign swap   = b[14:0] > a[14:0];
    assign op_l   = swap ? b : a;
    assign op_s   = swap ? a : b;
    assign shift  = get_exp(op_l) - get_exp(op_s);
    assign mant_l = {1'b1, get_mant(op_l)};
    assign mant_s = {1'b1, get_mant(op_s)} >> shift;

    logic [11:0]       raw;
    logic [3:0]        lead;
    logic [9:0]        norm;
    logic [9:0]        mant;
    logic signed [6:0] exp_res;

    // Add or subtract aligned mantissas, then renormalise and clamp
    always_comb begin
        raw     = '0;
        lead    = '0;
        norm    = '0;
        mant    = '0;
        exp_res = '0;
        sum     = FP16_ZERO;
        if (is_zero(a) && is_zero(b)) begin
            sum = FP16_ZERO;
        end else if (is_zero(a)) begin
            sum = b;
        end else if (is_zero(b)) begin
            sum = a;
        end else if (get_sign(op_l) == get_sign(op_s)) begin
            raw = {1'b0, mant_l} + {1'b0, mant_s};
            if (raw[11]) begin
                exp_res = 7'(get_exp(op_l)) + 7'd1;
                mant    = raw[10:1];
            end else begin
                exp_res = 7'(get_exp(op_l));
                mant    = raw[9:0];
            end
            if (exp_res >= 7'sd31)
                sum = {get_sign(op_l), FP16_MAX_MAG};
            else
                sum = {get_sign(op_l), exp_res[4:0], mant};
        end else begin
            raw = {1'b0, mant_l} - {1'b0, mant_s};
            if (raw != '0) begin
                for (int i = 0; i < 11; i++)
                    if (raw[i]) lead = 4'(10 - i);
                norm    = 10'(raw[10:0] << lead);
                exp_res = 7'(get_exp(op_l)) - 7'(lead);
                if (exp_res > 7'sd0)
                    sum = {get_sign(op_l), exp_res[4:0], norm};
            end
        end
    end

endmodule

// File: rtl/fp16_mac_unit.sv
// Streaming FP16 dot-product stage: registered multiply, then accumulate
// through fp16_add_core. Output backpressure freezes the whole pipeline.
module fp16_mac_unit
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        busy
);

    logic        adv;
    logic        p_val;
    logic        p_last;
    logic [15:0] p_prod;
    logic [15:0] acc;
    logic        acc_nonempty;
    logic [15:0] add_res;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign busy     = p_val | acc_nonempty;

    logic [11:0]       prod_top;
    logic signed [6:0] mul_exp;
    logic [9:0]        mul_mant;
    logic [15:0]       mul_res;

    // Truncating multiplier; exp field 31 is an ordinary value and saturates
    always_comb begin
        prod_top = 12'((22'({1'b1, get_mant(in_a)}) * 22'({1'b1, get_mant(in_b)})) >> 10);
        mul_exp  = 7'(get_exp(in_a)) + 7'(get_exp(in_b)) - 7'(BIAS)
                 + (prod_top[11] ? 7'd1 : 7'd0);
        mul_mant = prod_top[11] ? prod_top[10:1] : prod_top[9:0];
        mul_res  = {get_sign(in_a) ^ get_sign(in_b), mul_exp[4:0], mul_mant};
        if (is_zero(in_a) || is_zero(in_b) || mul_exp <= 7'sd0)
            mul_res = FP16_ZERO;
        else if (mul_exp >= 7'sd31)
            mul_res = {get_sign(in_a) ^ get_sign(in_b), FP16_MAX_MAG};
    end

    // Stage 1: capture the product of the accepted element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_val  <= 1'b0;
            p_last <= 1'b0;
            p_prod <= FP16_ZERO;
        end else if (adv) begin
            p_val  <= in_valid;
            p_last <= in_last;
            p_prod <= mul_res;
        end
    end

    fp16_add_core u_add (
        .a   (acc),
        .b   (p_prod),
        .sum (add_res)
    );

    // Stage 2: accumulate, or emit the finished sum and restart at +0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= FP16_ZERO;
            acc_nonempty <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= FP16_ZERO;
        end else if (adv) begin
            out_valid <= p_val & p_last;
            if (p_val) begin
                if (p_last) begin
                    out_sum      <= add_res;
                    acc          <= FP16_ZERO;
                    acc_nonempty <= 1'b0;
                end else begin
                    acc          <= add_res;
                    acc_nonempty <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp16_mac_unit.sv
// Bench for fp16_mac_unit: directed vectors plus randomized traffic,
// expected sums from a real-arithmetic model queued and checked by a monitor.
module tb_fp16_mac_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_a = 16'h0;
    logic [15:0] in_b = 16'h0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] out_sum;

    int          tests = 0;
    int          fails = 0;
    int          rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    logic [15:0] exp_q[$];
    logic [15:0] acc_m = 16'h0;

    fp16_mac_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (real arithmetic) ----------------
    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic real fval(input logic [15:0] x);
        real v;
        if (x[14:10] == 5'd0) return 0.0;
        v = (1024.0 + x[9:0]) * pow2(int'(x[14:10]) - 25);
        return x[15] ? -v : v;
    endfunction

    // Round toward zero to 11 significant bits, clamp to the FP16 range
    function automatic logic [15:0] enc(input real r);
        real mag;
        int  k;
        int  m;
        if (r == 0.0) return 16'h0000;
        mag = (r < 0.0) ? -r : r;
        k = 0;
        while (mag >= pow2(k + 1)) k++;
        while (mag < pow2(k)) k--;
        if (k + 15 >= 31) return {r < 0.0, 15'h7BFF};
        if (k + 15 <= 0) return 16'h0000;
        m = $rtoi(mag / pow2(k - 10)) - 1024;
        return {r < 0.0, 5'(k + 15), 10'(m)};
    endfunction

    function automatic logic [15:0] model_mul(input logic [15:0] a, input logic [15:0] b);
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return 16'h0000;
        return enc(fval(a) * fval(b));
    endfunction

    // Smaller operand truncated onto the larger operand's ulp grid first
    function automatic logic [15:0] model_add(input logic [15:0] x, input logic [15:0] y);
        real vx, vy, l, s, ulp, sa;
        logic [15:0] lf;
        vx = fval(x);
        vy = fval(y);
        if (((vx < 0.0) ? -vx : vx) >= ((vy < 0.0) ? -vy : vy)) begin
            l = vx; s = vy; lf = x;
        end else begin
            l = vy; s = vx; lf = y;
        end
        if (l == 0.0) return 16'h0000;
        ulp = pow2(int'(lf[14:10]) - 25);
        sa  = $floor(((s < 0.0) ? -s : s) / ulp) * ulp;
        if (s < 0.0) sa = -sa;
        return enc(l + sa);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        #1;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready is 0, expected 1 within 500 cycles");
        end else begin
            acc_m = model_add(acc_m, model_mul(a, b));
            if (last) begin
                exp_q.push_back(acc_m);
                acc_m = 16'h0000;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        rdy_mode = 1;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    function automatic logic [15:0] rand_op();
        int sel = $urandom_range(0, 9);
        if (sel == 0) return 16'($urandom);
        if (sel == 1) return {1'($urandom), ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31, 10'($urandom)};
        return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
    endfunction

    // ---------------- out_ready driver ----------------
    initial forever begin
        @(negedge clk);
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid) begin
            check("in_ready_hold", {15'b0, in_ready}, {15'b0, out_ready});
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got %h, expected no result", out_sum);
                end else begin
                    check("out_sum", out_sum, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        #3;
        check("rst_out_valid", {15'b0, out_valid}, 16'h0);
        check("rst_out_sum",   out_sum, 16'h0000);
        check("rst_busy",      {15'b0, busy}, 16'h0);
        check("rst_in_ready",  {15'b0, in_ready}, 16'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // single element with latency check
        send(16'h3E00, 16'h4000, 1'b1);
        idle();
        #2;
        check("lat_t1_valid", {15'b0, out_valid}, 16'h0);
        @(negedge clk);
        #2;
        check("lat_t2_valid", {15'b0, out_valid}, 16'h1);
        check("lat_t2_sum",   out_sum, 16'h4200);
        drain();

        // dot product, back-to-back
        send(16'h3E00, 16'h4000, 1'b0);
        send(16'h4100, 16'h3C00, 1'b1);
        drain();

        // cancellation, then accumulator restart
        send(16'hBE00, 16'h3C00, 1'b0);
        send(16'h3E00, 16'h3C00, 1'b1);
        send(16'h3C00, 16'h3C00, 1'b1);
        drain();

        // saturation and flush
        send(16'h7BFF, 16'h4000, 1'b1);
        send(16'h0400, 16'h3800, 1'b1);
        send(16'h0000, 16'h4200, 1'b1);
        drain();

        // backpressure
        rdy_mode = 0;
        @(negedge clk);
        send(16'h3C00, 16'h4000, 1'b1);
        send(16'h4200, 16'h3C00, 1'b1);
        idle();
        repeat (3) @(negedge clk);
        #2;
        check("bp_in_ready",  {15'b0, in_ready}, 16'h0);
        check("bp_out_valid", {15'b0, out_valid}, 16'h1);
        check("bp_out_sum",   out_sum, 16'h4000);
        check("bp_busy",      {15'b0, busy}, 16'h1);
        drain();

        // reset mid-vector
        send(16'h3C00, 16'h3C00, 1'b0);
        send(16'h4000, 16'h4000, 1'b0);
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", {15'b0, out_valid}, 16'h0);
        check("mrst_out_sum",   out_sum, 16'h0000);
        check("mrst_busy",      {15'b0, busy}, 16'h0);
        check("mrst_in_ready",  {15'b0, in_ready}, 16'h1);
        acc_m = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h3C00, 16'h3C00, 1'b1);
        drain();

        // randomized traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) idle();
            send(rand_op(), rand_op(), (i == 399) || ($urandom_range(0, 3) == 0));
        end
        drain();
        check("end_busy",      {15'b0, busy}, 16'h0);
        check("end_out_valid", {15'b0, out_valid}, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp16_mac_unit.md
# fp16_mac_unit

Streaming FP16 multiply-accumulate stage for the NPU datapath. It computes dot products over vectors of (a, b) element pairs. Each element pair is multiplied into an FP16 product, and the products are accumulated through the combinational FP16 adder. When the last element of a vector arrives, the block emits the finished sum. It sits directly upstream of result write-back and feeds the FP16 adder its operands every cycle.

## Interface
Parameters: none. The format is fixed IEEE binary16 layout: sign[15], exp[14:10], mant[9:0], bias 15.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  element pair present
- in_ready  out  1  block can accept an element this cycle
- in_a  in  16  FP16 operand a
- in_b  in  16  FP16 operand b
- in_last  in  1  marks final element of the current vector
- out_valid  out  1  out_sum holds a finished dot product
- out_ready  in  1  consumer accepts out_sum
- out_sum  out  16  FP16 dot-product result
- busy  out  1  partial accumulation or product in flight

## Operation
- Accept rule: element accepted when in_valid & in_ready.
- Stage 1, multiply. Results are registered into p_val, p_last and p_prod.
  - Exponent field 0 on either operand: product = +0x0000 (subnormals flushed).
  - Otherwise: sign = sa^sb; 11×11-bit mantissa product (hidden 1 restored); exp = ea+eb−15.
  - If product bit 21 is set: shift right 1 and exp+1.
  - Mantissa is truncated (no rounding).
  - exp ≥ 31: saturate to sign|0x7BFF.
  - exp ≤ 0: +0x0000.
  - An exponent field of 31 on an input is treated as an ordinary value, so it saturates.
- Stage 2, accumulate:
  - sum = fp16_add_core(acc, p_prod).
  - If p_val & !p_last: acc ← sum.
  - If p_val & p_last: out_sum ← sum, out_valid ← 1, acc ← +0x0000.
- Adder rules: operands aligned with truncation; a zero result is always +0x0000; overflow saturates to ±0x7BFF; underflow gives +0x0000.
- Single-element vector: out_sum = a·b.
- busy = p_val | (acc_nonempty flag). acc_nonempty is set by a non-last accumulate and cleared on last.

## Timing
- Reset values: in_ready 1 (after deassert), out_valid 0, out_sum 0x0000, busy 0, acc 0x0000, p_val 0.
- Reset mid-operation discards the partial accumulator, the in-flight product and any unconsumed result.
- Advance enable: adv = ~out_valid | out_ready. Both stages update only when adv = 1.
- in_ready = adv (combinational from out_valid/out_ready).
- Latency:
  - Last element accepted in cycle t → out_valid = 1 in cycle t+2, with out_sum stable.
  - Throughput is one element per cycle while adv = 1.
- Output hold: out_valid & ~out_ready freezes out_sum, both pipeline stages and in_ready = 0. No element is lost or duplicated.
- Same-cycle drain and replace: out_valid & out_ready while a new last product is in stage 2 loads the new result, and out_valid stays 1.
- out_valid clears the cycle after a handshake if no new result is loaded.
- A last element may be followed immediately by the next vector's first element; the accumulator restarts at +0.

## Structure
- Shared package fp16_pkg holds:
  - EXP_W = 5, MANT_W = 10, BIAS = 15
  - FP16_ZERO = 16'h0000, FP16_MAX_MAG = 15'h7BFF
  - field-extract helpers
- Sub-module fp16_add_core: combinational FP16 adder implementing the adder rules above. The stage-2 instance is its only use.
- The multiplier is inline in the top module (one always block plus the registered stage).

## Test plan
- Single element: a = 0x3E00 (1.5), b = 0x4000 (2.0), last = 1 → out_sum 0x4200 (3.0), 2 cycles after accept.
- Dot product: (0x3E00·0x4000), (0x4100·0x3C00, last) → out_sum 0x4580 (5.5). Back-to-back, out_ready tied 1.
- Cancellation: (0xBE00·0x3C00), (0x3E00·0x3C00, last) → 0x0000. Next vector 0x3C00·0x3C00 (last) → 0x3C00, confirming the accumulator cleared.
- Saturation and flush:
  - 0x7BFF·0x4000 (last) → 0x7BFF.
  - 0x0400·0x3800 (last) → 0x0000.
  - 0x0000·0x4200 (last) → 0x0000.
- Backpressure: two single-element vectors (1.0·2.0, 3.0·1.0) with out_ready = 0 → in_ready drops, out_sum holds 0x4000. Raise out_ready → 0x4000 then 0x4200, each exactly once.
- Reset mid-vector: accept 2 non-last elements, pulse rst_n low asynchronously → all outputs return to reset values. Then 0x3C00·0x3C00 (last) → 0x3C00.
